// File: rtl/sad_luma16x16_pkg.sv
// Shared intra-prediction definitions: mode encodings, macroblock geometry,
// SAD FSM states and the 8-bit saturation helper.
package sad_luma16x16_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } sad_state_e;

  localparam logic [1:0] MODE_V  = 2'd0;
  localparam logic [1:0] MODE_H  = 2'd1;
  localparam logic [1:0] MODE_DC = 2'd2;

  localparam int MB_ROWS   = 16;
  localparam int MB_COLS   = 16;
  localparam int NUM_MODES = 3;

  function automatic logic [7:0] sat8(input logic [31:0] v);
    return (v > 32'd255) ? 8'd255 : v[7:0];
  endfunction

endpackage

// File: rtl/sad_luma16x16_row_sad16.sv
// Combinational row SAD for one prediction mode: sum of |orig-pred| over 16
// samples plus the 16 two's-complement residues (low 8 bits of orig-pred).
module row_sad16
  import sad_luma16x16_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic [MB_COLS-1:0][PIX_W-1:0] orig,
  input  logic [MB_COLS-1:0][PIX_W-1:0] pred,
  output logic [PIX_W+3:0]              sad,
  output logic [MB_COLS-1:0][7:0]       res
);

  // Per-sample signed difference, magnitude and residue, summed across the row
  always_comb begin
    logic signed [PIX_W:0] diff;
    logic [PIX_W-1:0]      mag;
    sad  = '0;
    res  = '0;
    diff = '0;
    mag  = '0;
    for (int c = 0; c < MB_COLS; c++) begin
      diff   = $signed({1'b0, orig[c]}) - $signed({1'b0, pred[c]});
      mag    = diff[PIX_W] ? PIX_W'(-diff) : diff[PIX_W-1:0];
      res[c] = 8'(diff);
      sad    = sad + (PIX_W+4)'(mag);
    end
  end

endmodule

// File: rtl/sad_luma16x16.sv
// 16x16 luma SAD engine for V/H/DC intra prediction: accumulates one row per
// accepted beat, stores residues and reports the best mode. Build option:
// SAD_SATURATE_EN selects min(sad,255) for sads instead of the top 8 bits.
module sad_luma16x16
  import sad_luma16x16_pkg::*;
#(
  parameter int SAD_W = 16,
  parameter int PIX_W = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [12:0]                   mbnumber_in,
  input  logic                          row_valid,
  output logic                          row_ready,
  input  logic [MB_COLS-1:0][PIX_W-1:0] orig_row,
  input  logic [MB_COLS-1:0][PIX_W-1:0] vpred_row,
  input  logic [MB_COLS-1:0][PIX_W-1:0] hpred_row,
  input  logic [MB_COLS-1:0][PIX_W-1:0] dcpred_row,
  output logic [NUM_MODES-1:0][7:0]     sads,
  output logic [NUM_MODES-1:0][SAD_W-1:0] sad_full,
  output logic [255:0][7:0]             vres,
  output logic [255:0][7:0]             hres,
  output logic [255:0][7:0]             dcres,
  output logic [1:0]                    best_mode,
  output logic [12:0]                   mbnumber,
  output logic                          done
);

  sad_state_e state, state_next;
  logic [3:0] row_cnt;
  logic       accept;
  logic       last_row;

  logic [NUM_MODES-1:0][MB_COLS-1:0][PIX_W-1:0] pred_rows;
  logic [NUM_MODES-1:0][PIX_W+3:0]              row_sads;
  logic [NUM_MODES-1:0][MB_COLS-1:0][7:0]       row_res;
  logic [NUM_MODES-1:0][SAD_W-1:0]              acc_next;
  logic [NUM_MODES-1:0][7:0]                    sads_next;
  logic [1:0]                                   best_next;
  logic [1:0]                                   best_vh;
  logic [SAD_W-1:0]                             min_vh;

  assign accept   = row_valid && row_ready;
  assign last_row = (row_cnt == 4'd15);

  assign pred_rows[MODE_V]  = vpred_row;
  assign pred_rows[MODE_H]  = hpred_row;
  assign pred_rows[MODE_DC] = dcpred_row;

  for (genvar m = 0; m < NUM_MODES; m++) begin : g_mode
    row_sad16 #(.PIX_W(PIX_W)) u_row_sad (
      .orig (orig_row),
      .pred (pred_rows[m]),
      .sad  (row_sads[m]),
      .res  (row_res[m])
    );
  end

  // Running sums including the current row, and their 8-bit summaries
  always_comb begin
    acc_next  = '0;
    sads_next = '0;
    for (int m = 0; m < NUM_MODES; m++) begin
      acc_next[m] = sad_full[m] + SAD_W'(row_sads[m]);
`ifdef SAD_SATURATE_EN
      sads_next[m] = sat8(32'(acc_next[m]));
`else
      sads_next[m] = acc_next[m][SAD_W-1 -: 8];
`endif
    end
  end

  // Strict less-than keeps ties on the lower mode index
  always_comb begin
    best_vh   = (acc_next[MODE_H] < acc_next[MODE_V]) ? MODE_H : MODE_V;
    min_vh    = (acc_next[MODE_H] < acc_next[MODE_V]) ? acc_next[MODE_H] : acc_next[MODE_V];
    best_next = (acc_next[MODE_DC] < min_vh) ? MODE_DC : best_vh;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start ? ACCUM : IDLE;
      ACCUM:   state_next = (accept && last_row) ? DONE : ACCUM;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Accumulators, residue storage and registered results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_ready <= 1'b0;
      done      <= 1'b0;
      row_cnt   <= 4'd0;
      sad_full  <= '0;
      sads      <= '0;
      best_mode <= 2'd0;
      mbnumber  <= 13'd0;
      vres      <= '0;
      hres      <= '0;
      dcres     <= '0;
    end else begin
      row_ready <= (state_next == ACCUM);
      done      <= (state_next == DONE);
      if (state == IDLE && start) begin
        sad_full <= '0;
        row_cnt  <= 4'd0;
        mbnumber <= mbnumber_in;
      end else if (accept) begin
        sad_full                      <= acc_next;
        row_cnt                       <= row_cnt + 4'd1;
        vres[{row_cnt, 4'd0} +: 16]   <= row_res[MODE_V];
        hres[{row_cnt, 4'd0} +: 16]   <= row_res[MODE_H];
        dcres[{row_cnt, 4'd0} +: 16]  <= row_res[MODE_DC];
        if (last_row) begin
          sads      <= sads_next;
          best_mode <= best_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_sad_luma16x16.sv
// Scoreboard bench for sad_luma16x16: directed macroblocks push expected
// results; a negedge monitor checks them whenever done pulses.
module tb_sad_luma16x16;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [12:0]        mbnumber_in;
  logic               row_valid;
  logic               row_ready;
  logic [15:0][7:0]   orig_row, vpred_row, hpred_row, dcpred_row;
  logic [2:0][7:0]    sads;
  logic [2:0][15:0]   sad_full;
  logic [255:0][7:0]  vres, hres, dcres;
  logic [1:0]         best_mode;
  logic [12:0]        mbnumber;
  logic               done;

  sad_luma16x16 #(.SAD_W(16), .PIX_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .mbnumber_in(mbnumber_in),
    .row_valid(row_valid), .row_ready(row_ready), .orig_row(orig_row),
    .vpred_row(vpred_row), .hpred_row(hpred_row), .dcpred_row(dcpred_row),
    .sads(sads), .sad_full(sad_full), .vres(vres), .hres(hres), .dcres(dcres),
    .best_mode(best_mode), .mbnumber(mbnumber), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int full[3];
    int best;
    int mb;
    int done_cyc;
    int idx;
    int vr;
    int hr;
    int dr;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   s_cyc = 0;
  logic prev_done = 1'b0;
  int   po, pv, ph, pd;
  int   sp_r = -1, sp_c = 0, sp_o = 0, sp_v = 0, sp_h = 0, sp_d = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sads_of(input int full);
`ifdef SAD_SATURATE_EN
    return (full > 255) ? 255 : full;
`else
    return (full >> 8) & 255;
`endif
  endfunction

  // Monitor: every done pulse pops one expectation
  always @(negedge clk) begin
    if (done) begin
      chk("done_one_cycle", {31'd0, prev_done}, 32'd0);
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("done_cycle", cyc, e.done_cyc);
        for (int m = 0; m < 3; m++) begin
          chk($sformatf("sad_full[%0d]", m), {16'd0, sad_full[m]}, e.full[m]);
          chk($sformatf("sads[%0d]", m), {24'd0, sads[m]}, sads_of(e.full[m]));
        end
        chk("best_mode", {30'd0, best_mode}, e.best);
        chk("mbnumber", {19'd0, mbnumber}, e.mb);
        chk("vres", {24'd0, vres[e.idx]}, e.vr);
        chk("hres", {24'd0, hres[e.idx]}, e.hr);
        chk("dcres", {24'd0, dcres[e.idx]}, e.dr);
      end
    end
    prev_done = done;
  end

  task automatic push(input int f0, f1, f2, best, mb, dcyc, idx, vr, hr, dr);
    exp_t x;
    x.full[0] = f0; x.full[1] = f1; x.full[2] = f2;
    x.best = best; x.mb = mb; x.done_cyc = dcyc;
    x.idx = idx; x.vr = vr; x.hr = hr; x.dr = dr;
    q.push_back(x);
  endtask

  task automatic set_pat(input int o, v, h, d);
    po = o; pv = v; ph = h; pd = d;
  endtask

  task automatic do_start(input int mb);
    start = 1'b1;
    mbnumber_in = 13'(mb);
    @(posedge clk); #1;
    start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic send_row(input int r);
    int n;
    for (int c = 0; c < 16; c++) begin
      orig_row[c] = 8'(po); vpred_row[c] = 8'(pv);
      hpred_row[c] = 8'(ph); dcpred_row[c] = 8'(pd);
    end
    if (r == sp_r) begin
      orig_row[sp_c] = 8'(sp_o); vpred_row[sp_c] = 8'(sp_v);
      hpred_row[sp_c] = 8'(sp_h); dcpred_row[sp_c] = 8'(sp_d);
    end
    row_valid = 1'b1;
    n = 0;
    while (!row_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!row_ready) begin
      checks++;
      failures++;
      $display("FAIL row_ready_timeout actual=0 expected=1 (row %0d)", r);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_rows(input int first, input int last, input int gap_row, input int gap_len);
    for (int r = first; r <= last; r++) begin
      send_row(r);
      if (r == gap_row) begin
        row_valid = 1'b0;
        repeat (gap_len) begin
          @(posedge clk); #1;
        end
      end
    end
    row_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=%0d expected=0 pending", q.size());
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mbnumber_in = 13'd0; row_valid = 1'b0;
    orig_row = '0; vpred_row = '0; hpred_row = '0; dcpred_row = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_sad_full0", {16'd0, sad_full[0]}, 32'd0);
    chk("rst_sad_full2", {16'd0, sad_full[2]}, 32'd0);
    chk("rst_sads1", {24'd0, sads[1]}, 32'd0);
    chk("rst_best_mode", {30'd0, best_mode}, 32'd0);
    chk("rst_mbnumber", {19'd0, mbnumber}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_row_ready", {31'd0, row_ready}, 32'd0);
    chk("rst_hres", {24'd0, hres[77]}, 32'd0);

    // Uniform offsets, back-to-back rows
    set_pat(100, 100, 90, 110);
    do_start(1);
    chk("ready_in_accum", {31'd0, row_ready}, 32'd1);
    push(0, 2560, 2560, 0, 1, s_cyc + 16, 200, 0, 10, 246);
    send_rows(0, 15, -1, 0);
    drain();
    chk("ready_in_idle", {31'd0, row_ready}, 32'd0);
    chk("stable_sad_full1", {16'd0, sad_full[1]}, 32'd2560);

    // Maximum difference, three-way tie
    set_pat(255, 0, 0, 0);
    do_start(2);
    push(65280, 65280, 65280, 0, 2, s_cyc + 16, 255, 255, 255, 255);
    send_rows(0, 15, -1, 0);
    drain();

    // Single mismatched sample at row 3 col 5 in H only
    set_pat(50, 50, 50, 50);
    sp_r = 3; sp_c = 5; sp_o = 10; sp_v = 10; sp_h = 20; sp_d = 10;
    do_start(3);
    push(0, 10, 0, 0, 3, s_cyc + 16, 53, 0, 246, 0);
    send_rows(0, 15, -1, 0);
    drain();
    sp_r = -1;

    // Five-cycle gap after row 7
    set_pat(100, 100, 90, 110);
    do_start(4);
    push(0, 2560, 2560, 0, 4, s_cyc + 21, 130, 0, 10, 246);
    send_rows(0, 15, 7, 5);
    drain();

    // Reset aborts after row 9; new macroblock 42
    set_pat(255, 0, 0, 0);
    do_start(5);
    send_rows(0, 9, -1, 0);
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_sad_full0", {16'd0, sad_full[0]}, 32'd0);
    chk("abort_mbnumber", {19'd0, mbnumber}, 32'd0);
    chk("abort_row_ready", {31'd0, row_ready}, 32'd0);
    set_pat(20, 25, 20, 19);
    do_start(42);
    chk("fresh_acc", {16'd0, sad_full[0]}, 32'd0);
    push(1280, 0, 256, 1, 42, s_cyc + 16, 17, 251, 0, 1);
    send_rows(0, 15, -1, 0);
    drain();

    // Start during ACCUM is ignored
    set_pat(30, 31, 29, 30);
    do_start(6);
    push(256, 256, 0, 2, 6, s_cyc + 16, 100, 255, 1, 0);
    send_rows(0, 3, -1, 0);
    start = 1'b1;
    mbnumber_in = 13'd7;
    send_row(4);
    start = 1'b0;
    send_rows(5, 15, -1, 0);
    drain();
    chk("ignored_start_mb", {19'd0, mbnumber}, 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sad_luma16x16.md
SAD_LUMA16X16 -- requirements
Module: sad_luma16x16

Interface
REQ-001 SHALL have parameter SAD_W, default 16, meaning the width of the full-precision SAD accumulators.
REQ-002 SHALL have parameter PIX_W, default 8, meaning the sample width of original and predicted pixels.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, a one-cycle pulse that opens a macroblock.
REQ-006 SHALL have port mbnumber_in, input, 13, the macroblock index, sampled on start.
REQ-007 SHALL have port row_valid, input, 1, meaning one row of 16 samples is presented.
REQ-008 SHALL have port row_ready, output, 1, meaning the block accepts a row this cycle.
REQ-009 SHALL have port orig_row, input, 16xPIX_W, the original luma row.
REQ-010 SHALL have ports vpred_row, hpred_row and dcpred_row, input, 16xPIX_W each, carrying the vertical, horizontal and DC predicted rows.
REQ-011 SHALL have port sads, output, 3x8, the saturated SADs indexed 0=V, 1=H, 2=DC.
REQ-012 SHALL have port sad_full, output, 3xSAD_W, the full-precision SADs.
REQ-013 SHALL have ports vres, hres and dcres, output, 256x8 each, holding the residues in raster order (index = row*16 + col).
REQ-014 SHALL have port best_mode, output, 2, the index of the minimum-SAD mode.
REQ-015 SHALL have port mbnumber, output, 13, the latched macroblock index.
REQ-016 SHALL have port done, output, 1, a one-cycle pulse that serves as the downstream saver's enable.

Function
REQ-017 SHALL implement the FSM states IDLE, ACCUM and DONE.
- IDLE -> ACCUM on start.
- ACCUM -> DONE on acceptance of row 15.
- DONE -> IDLE unconditionally after one cycle.
REQ-018 SHALL assert row_ready only in ACCUM; a row SHALL be accepted when row_valid && row_ready.
REQ-019 SHALL, on start in IDLE, clear all three accumulators and the 4-bit row counter, and latch mbnumber_in into mbnumber.
REQ-020 SHALL, per accepted row r, add sum over c of |orig[c]-pred[c]| into each mode's accumulator.
- Differences are computed as (PIX_W+1)-bit signed values.
- Each absolute value is PIX_W bits.
REQ-021 SHALL write the residues for each accepted row into vres, hres and dcres at indices r*16..r*16+15, as the low 8 bits of orig-pred in two's complement.
REQ-022 SHALL increment the row counter on each accepted row; row 15 SHALL be the last row of the macroblock.
REQ-023 SHALL assert done for exactly one cycle, in the cycle after row 15 is accepted; sads, sad_full, best_mode, residues and mbnumber SHALL be final and stable from that cycle until the next start.
REQ-024 SHALL compute best_mode as the lowest index among the modes with the minimum sad_full; ties SHALL resolve to V over H over DC.
REQ-025 SHALL ignore start when the FSM is in ACCUM or DONE.
REQ-026 SHALL ignore row_valid when the FSM is in IDLE or DONE.
REQ-027 SHALL allow row_valid gaps of any length in ACCUM; no state SHALL change in cycles where no row is accepted.
REQ-028 SHALL NOT let sad_full wrap: 256*255 = 65280 fits in SAD_W=16; SAD_W SHALL be at least 16.

Reset
REQ-029 SHALL, on reset, force the FSM to IDLE and clear to zero: row counter, accumulators, sads, sad_full, best_mode, mbnumber, row_ready and done.
REQ-030 SHALL clear residue storage on reset.
REQ-031 SHALL treat reset asserted mid-macroblock as an abort: no done is produced, and the next start begins a fresh macroblock.

Configuration
REQ-032 SHALL, with SAD_SATURATE_EN defined, drive sads[m] = min(sad_full[m], 255).
REQ-033 SHALL, without SAD_SATURATE_EN, drive sads[m] = sad_full[m][SAD_W-1 -: 8], i.e. a coarse scaled value.
REQ-034 SHALL compute best_mode from sad_full in both builds.

Structure
REQ-035 SHALL take the mode encodings (MODE_V=0, MODE_H=1, MODE_DC=2), MB_ROWS=16, MB_COLS=16 and the FSM state typedef from a shared intra-prediction package.
REQ-036 SHALL instantiate one sub-module, row_sad16, that is combinational and returns the row SAD and the 16 residues for one mode; it SHALL be instantiated three times.

Verification
REQ-037 SHALL cover this scenario: all rows orig=100, vpred=100, hpred=90, dcpred=110 -> sad_full={0,2560,2560}, best_mode=0, sads={0,255,255} with SAD_SATURATE_EN and {0,10,10} without, done high exactly 17 cycles after start with back-to-back rows.
REQ-038 SHALL cover this scenario: orig=255, vpred=0, hpred=0, dcpred=0 -> sad_full=65280 for all three modes, no wrap, best_mode=0 by tie-break.
REQ-039 SHALL cover this scenario: row 3 col 5 orig=10, hpred=20, all other samples matched -> hres[53]=8'hF6, sad_full[H]=10, best_mode=0.
REQ-040 SHALL cover this scenario: row_valid deasserted for 5 cycles after row 7 -> done delayed by 5 cycles and identical SAD results.
REQ-041 SHALL cover this scenario: reset pulsed after row 9, then a new start with mbnumber_in=42 -> no done before the new macroblock completes, accumulators start at zero, and mbnumber=42.
REQ-042 SHALL cover this scenario: start pulsed during ACCUM with mbnumber_in=7 -> ignored, with mbnumber unchanged and the row count unaffected.
